// File: rtl/alu_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub32.sv
// Combinational subtractor: diff = a - b, borrow set when b > a.
module sub32
    import alu_pkg::*;
#(
    parameter int unsigned W = DEFAULT_WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/alu_div32.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first,
// with a one-cycle divide-by-zero shortcut.
module alu_div32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] div_b;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             diff_msb_unused;

    // Partial remainder gains the next dividend bit; quotient bits shift into dvd.
    assign shifted = {rem, dvd[WIDTH-1]};

    sub32 #(.W(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, div_b}),
        .diff   (diff),
        .borrow (borrow)
    );

    // After a successful subtract the result is below the divisor, so the top bit is always zero.
    assign diff_msb_unused = diff[WIDTH];
    assign rem_next        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_next        = {dvd[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            rem   <= '0;
            div_b <= '0;
            Q     <= '0;
            R     <= '0;
            DZ    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && start) begin
                        div_b <= B;
                        dvd   <= A;
                        rem   <= '0;
                        cnt   <= '0;
                        if (B == '0) begin
                            state <= DONE;
                            Q     <= '1;
                            R     <= A;
                            DZ    <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Q     <= dvd_next;
                        R     <= rem_next;
                        DZ    <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div32.sv
// Self-checking bench for alu_div32: vector table, corner sequences and a
// random sweep, with results scored against a queue of expected values.
module tb_alu_div32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Q;
    logic [31:0] R;
    logic        DZ;
    logic        busy;
    logic        done;

    int   n_cmp;
    int   n_err;
    int   n_done;
    res_t sb[$];
    vec_t tbl[8];

    alu_div32 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .DZ    (DZ),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t res;
        if (b == 32'd0) begin
            res.q  = 32'hFFFF_FFFF;
            res.r  = a;
            res.dz = 1'b1;
        end else begin
            res.q  = a / b;
            res.r  = a % b;
            res.dz = 1'b0;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                res_t e;
                e = sb.pop_front();
                check("sb_q", 64'(Q), 64'(e.q));
                check("sb_r", 64'(R), 64'(e.r));
                check("sb_dz", 64'(DZ), 64'(e.dz));
            end
        end
    end

    // lat = edges after the accept edge until done is seen; bcnt = samples with busy high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        A     = a;
        B     = b;
        en    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(a, b));
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        if (!done) begin
            fail_now("done_timeout");
            sb.delete();
        end else begin
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          nd0;
        logic [31:0] ra;
        logic [31:0] rb;

        n_cmp  = 0;
        n_err  = 0;
        n_done = 0;
        rst    = 1'b1;
        en     = 1'b0;
        start  = 1'b0;
        A      = '0;
        B      = '0;

        tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
        tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
        tbl[2] = '{32'd3,          32'd10,         32'd0,          32'd3,   1'b0};
        tbl[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,   1'b1};
        tbl[4] = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0};
        tbl[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
        tbl[6] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,   1'b0};
        tbl[7] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 64'(Q), 64'd0);
        check("rst_r", 64'(R), 64'd0);
        check("rst_dz", 64'(DZ), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, lat, bcnt);
            check("tbl_q", 64'(Q), 64'(tbl[i].q));
            check("tbl_r", 64'(R), 64'(tbl[i].r));
            check("tbl_dz", 64'(DZ), 64'(tbl[i].dz));
            check("tbl_latency", 64'(lat), (tbl[i].b == 32'd0) ? 64'd0 : 64'd32);
            check("tbl_busy_cycles", 64'(bcnt), (tbl[i].b == 32'd0) ? 64'd0 : 64'd32);
        end

        // A second start while busy must be ignored.
        nd0 = n_done;
        @(negedge clk);
        A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(32'd100, 32'd7));
        repeat (5) @(posedge clk);
        @(negedge clk);
        A = 32'd9; B = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("busy_ign_q", 64'(Q), 64'd14);
        check("busy_ign_r", 64'(R), 64'd2);
        check("busy_ign_pulses", 64'(n_done - nd0), 64'd1);
        check("busy_ign_idle", 64'(busy), 64'd0);

        // Reset in the tenth RUN cycle abandons the operation.
        nd0 = n_done;
        @(negedge clk);
        A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(32'd100, 32'd7));
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_q", 64'(Q), 64'd0);
        check("midrst_r", 64'(R), 64'd0);
        check("midrst_dz", 64'(DZ), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(n_done - nd0), 64'd0);
        do_op(32'd100, 32'd7, lat, bcnt);
        check("post_rst_q", 64'(Q), 64'd14);
        check("post_rst_r", 64'(R), 64'd2);

        // Start with en low is ignored.
        nd0 = n_done;
        @(negedge clk);
        en = 1'b0; A = 32'd9; B = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        check("en0_busy", 64'(busy), 64'd0);
        check("en0_done", 64'(done), 64'd0);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("en0_no_done", 64'(n_done - nd0), 64'd0);
        check("en0_q_held", 64'(Q), 64'd14);
        en = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 10)
                0: rb = 32'd0;
                1: begin
                    ra = $urandom_range(0, 32'h7FFF_FFFF);
                    rb = ra + 32'd1 + 32'($urandom_range(0, 1000));
                end
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op(ra, rb, lat, bcnt);
            if (rb != 32'd0) begin
                check("rnd_identity", 64'(Q) * 64'(rb) + 64'(R), 64'(ra));
                check("rnd_r_lt_b", 64'(R < rb), 64'd1);
                check("rnd_latency", 64'(lat), 64'd32);
            end else begin
                check("rnd_dz", 64'(DZ), 64'd1);
                check("rnd_dz_latency", 64'(lat), 64'd0);
            end
        end

        repeat (2) @(posedge clk);
        if (sb.size() != 0) fail_now("sb_leftover");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
